// File: rtl/adrv9001_spi_master.sv
// Byte-stream SPI master (mode 0, MSB first) for the ADRV9001 control port.
// Ports: clk/rst; s_axis byte+enable in (1-deep TX buffer); m_axis RX FIFO out;
// spi_csn/spi_clk/spi_mosi/spi_miso; busy status; sticky rx_overflow.
module adrv9001_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_enable,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       busy,
  output logic       rx_overflow
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, GAP, HOLD, IDLE_GAP
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] bits;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic       cur_en;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tick;
  logic       tx_pop;
  logic       rx_push;

  assign tick    = (cnt == DIV_M1);
  assign tx_pop  = tx_full && (state == IDLE || state == GAP);
  // 8th falling edge: rx_shift already holds the full byte
  assign rx_push = (state == HIGH) && tick && (bits == 4'd7);

  assign s_axis_tready = ~tx_full;
  assign busy          = (state != IDLE) | tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_full <= 1'b0;
      tx_data <= '0;
      tx_en   <= 1'b0;
    end else if (tx_pop) begin
      tx_full <= 1'b0;
    end else if (s_axis_tvalid && !tx_full) begin
      tx_full <= 1'b1;
      tx_data <= s_axis_tdata;
      tx_en   <= s_axis_enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bits     <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      cur_en   <= 1'b0;
      spi_csn  <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
      unique case (state)
        IDLE, GAP: begin
          cnt <= '0;
          if (state == IDLE) begin
            spi_csn <= 1'b1;
            spi_clk <= 1'b0;
          end
          if (tx_full) begin
            tx_shift <= tx_data;
            spi_mosi <= tx_data[7];
            cur_en   <= tx_en;
            bits     <= '0;
            spi_csn  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: if (tick) begin
          spi_clk  <= 1'b1;
          rx_shift <= {rx_shift[6:0], spi_miso};
          state    <= HIGH;
        end
        HIGH: if (tick) begin
          spi_clk <= 1'b0;
          bits    <= bits + 4'd1;
          state   <= LOW;
          if (bits != 4'd7) begin
            tx_shift <= tx_shift << 1;
            spi_mosi <= tx_shift[6];
          end
        end
        LOW: if (tick) begin
          if (bits == 4'd8) begin
            state <= cur_en ? GAP : HOLD;
          end else begin
            spi_clk  <= 1'b1;
            rx_shift <= {rx_shift[6:0], spi_miso};
            state    <= HIGH;
          end
        end
        HOLD: if (tick) begin
          spi_csn <= 1'b1;
          state   <= IDLE_GAP;
        end
        IDLE_GAP: if (tick) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]  mem [RX_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = m_axis_tready & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign push_ok = rx_push & (~full | pop);

  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? 8'd0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (rx_push && full && !pop) rx_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adrv9001_spi_master.sv
// Scoreboard bench for adrv9001_spi_master: SPI slave model with queued
// MISO bytes, MOSI byte checker and RX FIFO pop monitor.
module tb_adrv9001_spi_master;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_enable = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       spi_csn;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
  logic       busy;
  logic       rx_overflow;

  adrv9001_spi_master #(.CLK_DIV(D), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_enable(s_axis_enable), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .busy(busy), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_mosi_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] exp_rx_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // SPI slave model
  logic       prev_csn = 1'b1;
  logic       prev_sclk = 1'b0;
  int         bidx = 0;
  logic       have = 1'b0;
  logic [7:0] cur = '0;
  logic [7:0] mshift = '0;
  int         csn_fall_cyc = 0;
  int         csn_low_len = 0;
  int         csn_rises = 0;
  int         sclk_rises = 0;
  int         sclk_at_rise = 0;

  always @(negedge clk) begin
    if (prev_csn === 1'b1 && spi_csn === 1'b0) csn_fall_cyc = cyc;
    if (prev_csn === 1'b0 && spi_csn === 1'b1) begin
      csn_low_len  = cyc - csn_fall_cyc;
      csn_rises++;
      sclk_at_rise = sclk_rises;
    end
    if (spi_csn === 1'b1 && bidx != 0) begin
      bidx = 0;
      have = 1'b0;
    end
    if (prev_sclk === 1'b0 && spi_clk === 1'b1) begin
      sclk_rises++;
      mshift = {mshift[6:0], spi_mosi};
      bidx++;
      if (bidx == 8) begin
        bidx = 0;
        have = 1'b0;
        if (exp_mosi_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mosi_extra: got %0h want none", mshift);
        end else begin
          chk("mosi_byte", mshift, exp_mosi_q.pop_front());
        end
      end
    end
    if (spi_csn === 1'b0 && !have && miso_q.size() > 0) begin
      cur  = miso_q.pop_front();
      have = 1'b1;
    end
    spi_miso  = have ? cur[3'(7 - bidx)] : 1'b0;
    prev_csn  = spi_csn;
    prev_sclk = spi_clk;
  end

  // RX FIFO monitor
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_rx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_extra: got %0h want none", m_axis_tdata);
      end else begin
        chk("rx_data", m_axis_tdata, exp_rx_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic en,
                      input logic [7:0] m, input bit exp_rx);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (s_axis_tready) break;
      @(posedge clk); #1;
    end
    if (k == 3000) tmo("send_ready");
    exp_mosi_q.push_back(d);
    miso_q.push_back(m);
    if (exp_rx) exp_rx_q.push_back(m);
    s_axis_tdata  = d;
    s_axis_enable = en;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input bit rp);
    int k;
    for (k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      if (rp) m_axis_tready = 1'($urandom_range(0, 1));
      if (!busy) break;
    end
    m_axis_tready = 1'b0;
    if (k == 4000) tmo("wait_idle");
  endtask

  task automatic drain(output int n);
    int k;
    n = 0;
    for (k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      if (!m_axis_tvalid) break;
      m_axis_tready = 1'b1;
      n++;
    end
    m_axis_tready = 1'b0;
    if (k == 64) tmo("drain");
  endtask

  task automatic pop_one();
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_mosi_q.delete();
    miso_q.delete();
    exp_rx_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    int s0;
    int k;
    int len;
    logic [7:0] first_m;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_csn", spi_csn, 1);
    chk("rst_sclk", spi_clk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", rx_overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    s0 = sclk_rises;
    send(8'hA5, 1'b0, 8'h3C, 1);
    wait_idle(0);
    chk("one_csn_len", csn_low_len, 18 * D);
    chk("one_rises", sclk_rises - s0, 8);
    chk("one_tvalid", m_axis_tvalid, 1);
    chk("one_tdata", m_axis_tdata, 8'h3C);
    drain(n);
    chk("one_pops", n, 1);

    r0 = csn_rises;
    s0 = sclk_rises;
    send(8'h80, 1'b1, 8'($urandom), 1);
    send(8'h12, 1'b1, 8'($urandom), 1);
    send(8'hFF, 1'b0, 8'($urandom), 1);
    wait_idle(0);
    chk("three_csn_rises", csn_rises - r0, 1);
    chk("three_rises_at_cs", sclk_at_rise - s0, 24);
    drain(n);
    chk("three_pops", n, 3);

    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++)
        send(8'($urandom), 1'(b != len - 1), 8'($urandom), 1);
      wait_idle(1);
    end
    drain(n);
    chk("rand_rx_left", exp_rx_q.size(), 0);
    chk("rand_mosi_left", exp_mosi_q.size(), 0);

    s0 = sclk_rises;
    send(8'h11, 1'b1, 8'($urandom), 1);
    send(8'h22, 1'b0, 8'($urandom), 1);
    chk("full_tready", s_axis_tready, 0);
    s_axis_tdata  = 8'h55;
    s_axis_enable = 1'b0;
    s_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    wait_idle(0);
    chk("ign_rises", sclk_rises - s0, 16);
    chk("ign_mosi_left", exp_mosi_q.size(), 0);
    drain(n);
    chk("ign_pops", n, 2);

    for (int i = 0; i < 17; i++) begin
      logic [7:0] m;
      m = 8'($urandom);
      if (i == 0) first_m = m;
      send(8'($urandom), 1'b0, m, i < 16);
    end
    wait_idle(0);
    chk("ovf_flag", rx_overflow, 1);
    chk("ovf_tvalid", m_axis_tvalid, 1);
    chk("ovf_head", m_axis_tdata, first_m);
    pop_one();
    chk("ovf_sticky", rx_overflow, 1);
    drain(n);
    chk("ovf_pops", n, 15);
    do_reset();
    chk("ovf_cleared", rx_overflow, 0);

    for (int i = 0; i < 16; i++)
      send(8'($urandom), 1'b0, 8'($urandom), 1);
    wait_idle(0);
    chk("fill_ovf", rx_overflow, 0);
    send(8'($urandom), 1'b0, 8'($urandom), 1);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!spi_csn) break;
    end
    if (k == 100) tmo("csn_fall");
    repeat (16 * D - 1) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    wait_idle(0);
    chk("simul_ovf", rx_overflow, 0);
    drain(n);
    chk("simul_pops", n, 16);
    chk("simul_rx_left", exp_rx_q.size(), 0);

    send(8'h77, 1'b0, 8'($urandom), 1);
    wait_idle(0);
    s0 = sclk_rises;
    send(8'h5A, 1'b0, 8'($urandom), 0);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sclk_rises == s0 + 4) break;
    end
    if (k == 200) tmo("fourth_rise");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_csn", spi_csn, 1);
    chk("arst_sclk", spi_clk, 0);
    chk("arst_mosi", spi_mosi, 0);
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_busy", busy, 0);
    exp_mosi_q.delete();
    miso_q.delete();
    exp_rx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(8'h01, 1'b0, 8'($urandom), 1);
    wait_idle(0);
    chk("post_csn_len", csn_low_len, 18 * D);
    drain(n);
    chk("post_pops", n, 1);
    chk("post_mosi_left", exp_mosi_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
